// File: rtl/result_writer.sv
// AVMM write master: stores one NDWORDS x 32-bit record as consecutive 16-bit
// halfwords at baseaddr + index*NDWORDS*4, low half of word 0 first.
module result_writer #(
  parameter int NDWORDS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [31:0]            baseaddr,
  input  logic [31:0]            index,
  input  logic                   write,
  input  logic [32*NDWORDS-1:0]  data,
  output logic                   iready,
  output logic                   o_done,
  output logic                   avm_m0_write,
  output logic [31:0]            avm_m0_address,
  output logic [15:0]            avm_m0_writedata,
  output logic [1:0]             avm_m0_byteenable,
  input  logic                   avm_m0_waitrequest
);

  // state | meaning
  // IDLE  | waiting for a request; iready=1, no bus activity
  // BUSY  | streaming halfwords of the latched record to the slave

  localparam int NHALF = 2 * NDWORDS;
  localparam int KW = (NHALF > 1) ? $clog2(NHALF) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NHALF - 1);
  localparam logic [31:0] STRIDE = 32'(NDWORDS * 4);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nx;
  logic [KW-1:0]         k, k_nx, k_inc;
  logic [32*NDWORDS-1:0] rec, rec_nx;
  logic [31:0]           addr_nx;
  logic [15:0]           wdata_nx;
  logic                  wr_nx;
  logic [1:0]            be_nx;
  logic                  done_nx;
  logic                  accept, xfer, last;

  assign iready = (state == IDLE);
  assign accept = write && (state == IDLE);
  assign xfer   = (state == BUSY) && avm_m0_write && !avm_m0_waitrequest;
  assign last   = (k == K_LAST);
  assign k_inc  = k + 1'b1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state             <= IDLE;
      k                 <= '0;
      rec               <= '0;
      avm_m0_write      <= 1'b0;
      avm_m0_address    <= '0;
      avm_m0_writedata  <= '0;
      avm_m0_byteenable <= 2'b00;
      o_done            <= 1'b0;
    end else begin
      state             <= state_nx;
      k                 <= k_nx;
      rec               <= rec_nx;
      avm_m0_write      <= wr_nx;
      avm_m0_address    <= addr_nx;
      avm_m0_writedata  <= wdata_nx;
      avm_m0_byteenable <= be_nx;
      o_done            <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (xfer && last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are computed one cycle ahead so they leave the block registered;
  // during a stall every field simply holds.
  always_comb begin
    k_nx     = k;
    rec_nx   = rec;
    addr_nx  = avm_m0_address;
    wdata_nx = avm_m0_writedata;
    wr_nx    = avm_m0_write;
    be_nx    = avm_m0_byteenable;
    done_nx  = 1'b0;
    if (accept) begin
      rec_nx   = data;
      k_nx     = '0;
      addr_nx  = baseaddr + index * STRIDE;
      wdata_nx = data[15:0];
      wr_nx    = 1'b1;
      be_nx    = 2'b11;
    end else if (xfer) begin
      if (last) begin
        wr_nx   = 1'b0;
        be_nx   = 2'b00;
        done_nx = 1'b1;
      end else begin
        k_nx     = k_inc;
        addr_nx  = avm_m0_address + 32'd2;
        wdata_nx = rec[{k_inc, 4'h0} +: 16];
      end
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: a vector table of records with optional
// stalls and busy-time pokes, plus back-to-back and mid-transfer reset sequences.
module tb_result_writer;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [31:0]   base = '0;
  logic [31:0]   idx = '0;
  logic          write = 1'b0;
  logic [127:0]  data = '0;
  logic          wreq = 1'b0;
  logic          iready, o_done, avm_write;
  logic [31:0]   avm_addr;
  logic [15:0]   avm_wdata;
  logic [1:0]    avm_be;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  result_writer #(.NDWORDS(ND)) dut (
    .i_clk(clk), .i_rstn(rstn), .baseaddr(base), .index(idx), .write(write),
    .data(data), .iready(iready), .o_done(o_done), .avm_m0_write(avm_write),
    .avm_m0_address(avm_addr), .avm_m0_writedata(avm_wdata),
    .avm_m0_byteenable(avm_be), .avm_m0_waitrequest(wreq)
  );

  always @(posedge clk) if (o_done) done_cnt++;

  typedef struct {
    logic [31:0]      base;
    logic [31:0]      idx;
    logic [127:0]     data;
    logic [31:0]      addr0;
    logic [7:0][15:0] hw;
    int               sh0, sc0, sh1, sc1;
    bit               poke;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a request, let it be accepted, then scramble the inputs.
  task automatic start(input vec_t v);
    @(negedge clk);
    base = v.base; idx = v.idx; data = v.data; write = 1'b1;
    chk("iready_before_accept", {31'b0, iready}, 32'd1);
    @(posedge clk); #1;
    write = 1'b0;
    base = v.base + 32'h100; idx = v.idx + 32'd1; data = ~v.data;
  endtask

  // Called #1 after the accept edge (cycle 1); follows the record to o_done.
  task automatic monitor(input vec_t v, input bit chain, input vec_t nv);
    int cyc = 1;
    int n = 0;
    int s0 = 0;
    int s1 = 0;
    bit seen = 1'b0;
    while (cyc < 80 && !seen) begin
      if (v.poke) begin
        if (cyc >= 2 && cyc <= 4) begin
          write = 1'b1; data = {4{32'hA5A5_5A5A}}; idx = 32'd9; base = 32'h0;
        end else if (cyc == 5) begin
          write = 1'b0;
        end
      end
      if (o_done) begin
        seen = 1'b1;
        chk("done_cycle", cyc, 9 + v.sc0 + v.sc1);
        chk("halfword_count", n, 8);
        chk("write_after_done", {31'b0, avm_write}, 32'd0);
        chk("be_after_done", {30'b0, avm_be}, 32'd0);
        chk("iready_in_done", {31'b0, iready}, 32'd1);
        wreq = 1'b0;
        if (chain) begin
          base = nv.base; idx = nv.idx; data = nv.data; write = 1'b1;
        end
      end else if (avm_write) begin
        if (n > 7) begin
          chk("extra_write", n, 7);
        end else begin
          chk("address", avm_addr, v.addr0 + 32'(2 * n));
          chk("writedata", {16'h0, avm_wdata}, {16'h0, v.hw[n]});
        end
        chk("byteenable", {30'b0, avm_be}, 32'd3);
        chk("iready_busy", {31'b0, iready}, 32'd0);
        if (n == v.sh0 && s0 < v.sc0) begin
          wreq = 1'b1; s0++;
        end else if (n == v.sh1 && s1 < v.sc1) begin
          wreq = 1'b1; s1++;
        end else begin
          wreq = 1'b0; n++;
        end
      end else begin
        chk("write_gap", {31'b0, avm_write}, 32'd1);
        wreq = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
    if (chain) begin
      write = 1'b0;
      chk("done_one_cycle", {31'b0, o_done}, 32'd0);
      chk("b2b_busy_resumes", {31'b0, avm_write}, 32'd1);
    end else begin
      chk("done_one_cycle", {31'b0, o_done}, 32'd0);
    end
  endtask

  initial begin
    int dcnt;
    vec_t nxt, v0;

    vecs[0] = '{base: 32'h0000_1000, idx: 32'd2,
                data: 128'h00000000_00000005_7FFFFFFF_00010002, addr0: 32'h0000_1020,
                hw: {16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0002},
                sh0: 0, sc0: 0, sh1: 0, sc1: 0, poke: 1'b0};
    vecs[1] = vecs[0];
    vecs[1].sc0 = 3; vecs[1].sh1 = 5; vecs[1].sc1 = 2;
    vecs[2] = '{base: 32'hFFFF_FFF8, idx: 32'd0,
                data: 128'h89ABCDEF_01234567_DEADBEEF_CAFEF00D, addr0: 32'hFFFF_FFF8,
                hw: {16'h89AB, 16'hCDEF, 16'h0123, 16'h4567, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D},
                sh0: 0, sc0: 0, sh1: 0, sc1: 0, poke: 1'b0};
    vecs[3] = '{base: 32'h2000_0000, idx: 32'h1000_0001,
                data: 128'h11112222_33334444_55556666_77778888, addr0: 32'h2000_0010,
                hw: {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888},
                sh0: 0, sc0: 0, sh1: 0, sc1: 0, poke: 1'b0};
    vecs[4] = vecs[0];
    vecs[4].poke = 1'b1;

    #2 rstn = 1'b0;
    #1;
    chk("rst_iready", {31'b0, iready}, 32'd1);
    chk("rst_done", {31'b0, o_done}, 32'd0);
    chk("rst_write", {31'b0, avm_write}, 32'd0);
    chk("rst_address", avm_addr, 32'd0);
    chk("rst_writedata", {16'h0, avm_wdata}, 32'd0);
    chk("rst_be", {30'b0, avm_be}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // waitrequest in IDLE must not start anything
    wreq = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_wreq_write", {31'b0, avm_write}, 32'd0);
    chk("idle_wreq_iready", {31'b0, iready}, 32'd1);
    wreq = 1'b0;

    for (int i = 0; i < 5; i++) begin
      start(vecs[i]);
      monitor(vecs[i], 1'b0, vecs[i]);
    end

    // back-to-back: second request presented in the o_done cycle
    nxt = vecs[0];
    nxt.idx = 32'd3;
    nxt.addr0 = 32'h0000_1030;
    dcnt = done_cnt;
    start(vecs[0]);
    monitor(vecs[0], 1'b1, nxt);
    monitor(nxt, 1'b0, nxt);
    @(posedge clk); #1;
    chk("b2b_done_pulses", done_cnt - dcnt, 2);

    // reset after the third accepted halfword
    dcnt = done_cnt;
    start(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_address", avm_addr, 32'h0000_1026);
    chk("pre_reset_write", {31'b0, avm_write}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("abort_write", {31'b0, avm_write}, 32'd0);
    chk("abort_be", {30'b0, avm_be}, 32'd0);
    chk("abort_iready", {31'b0, iready}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - dcnt, 0);
    chk("abort_idle_write", {31'b0, avm_write}, 32'd0);
    v0 = vecs[0];
    v0.idx = 32'd0;
    v0.addr0 = 32'h0000_1000;
    start(v0);
    monitor(v0, 1'b0, v0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
